// File: rtl/pipelinestages_pkg.sv
// Shared pipeline-register layouts and stage FSM encodings for the in-order core.
// ex_mem_t/mem_wb_t are the EX/MEM and MEM/WB register contents.
package pipelinestages_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] alu_result;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
  } ex_mem_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] alu_or_mem_val;
    logic [4:0]  rd;
    logic        reg_write;
  } mem_wb_t;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_stage.sv
// MEM stage: word data-memory access, MEM/WB register one cycle after completion.
// Stalls upstream combinationally while a request waits on dmem_ready_i; MEM_ALIGN_CHECK_EN adds misalign trapping.
module mem_stage
  import pipelinestages_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  ex_mem_t     ex_mem_i,
  output logic        stall_o,
  output mem_wb_t     mem_wb_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic [31:0] dmem_rdata_i,
  input  logic        dmem_ready_i
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic        misalign_err_o
`endif
);

  mem_state_e  state_q, state_d;
  mem_wb_t     wb_d;

  logic [31:0] lat_alu_q, lat_wdata_q;
  logic [4:0]  lat_rd_q;
  logic        lat_we_q, lat_reg_write_q, lat_mem_to_reg_q;

  logic [31:0] cur_alu, cur_wdata;
  logic [4:0]  cur_rd;
  logic        cur_we, cur_rw, cur_m2r;
  logic        is_mem, misalign, complete, latch_en;

  always_comb begin
    is_mem = ex_mem_i.valid && (ex_mem_i.mem_read || ex_mem_i.mem_write);
`ifdef MEM_ALIGN_CHECK_EN
    misalign = is_mem && (ex_mem_i.alu_result[1:0] != 2'b00);
`else
    misalign = 1'b0;
`endif
  end

  // Source of the access: live EX/MEM contents in IDLE, the held copy in WAIT.
  always_comb begin
    cur_alu   = ex_mem_i.alu_result;
    cur_wdata = ex_mem_i.rs2;
    cur_we    = ex_mem_i.mem_write;
    cur_rd    = ex_mem_i.rd;
    cur_rw    = ex_mem_i.reg_write && !(ex_mem_i.mem_read && ex_mem_i.mem_write);
    cur_m2r   = ex_mem_i.mem_to_reg && is_mem;
    if (state_q == MEM_WAIT) begin
      cur_alu   = lat_alu_q;
      cur_wdata = lat_wdata_q;
      cur_we    = lat_we_q;
      cur_rd    = lat_rd_q;
      cur_rw    = lat_reg_write_q;
      cur_m2r   = lat_mem_to_reg_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    wb_d       = '0;
    dmem_req_o = 1'b0;
    stall_o    = 1'b0;
    complete   = 1'b0;
    latch_en   = 1'b0;
    case (state_q)
      MEM_IDLE: begin
        if (ex_mem_i.valid && !misalign) begin
          if (!is_mem) begin
            complete = 1'b1;
          end else begin
            dmem_req_o = 1'b1;
            if (dmem_ready_i) begin
              complete = 1'b1;
            end else begin
              stall_o  = 1'b1;
              latch_en = 1'b1;
              state_d  = MEM_WAIT;
            end
          end
        end
      end
      MEM_WAIT: begin
        dmem_req_o = 1'b1;
        if (dmem_ready_i) begin
          complete = 1'b1;
          state_d  = MEM_IDLE;
        end else begin
          stall_o = 1'b1;
        end
      end
    endcase
    if (complete) begin
      wb_d.valid          = 1'b1;
      wb_d.alu_or_mem_val = cur_m2r ? dmem_rdata_i : cur_alu;
      wb_d.rd             = cur_rd;
      wb_d.reg_write      = cur_rw && (cur_rd != 5'd0);
    end
    // Nothing may reach memory or freeze the pipe while held in reset.
    if (!rst_n) begin
      dmem_req_o = 1'b0;
      stall_o    = 1'b0;
    end
  end

  assign dmem_we_o    = cur_we;
  assign dmem_wdata_o = cur_wdata;
`ifdef MEM_ALIGN_CHECK_EN
  assign dmem_addr_o  = cur_alu;
`else
  assign dmem_addr_o  = {cur_alu[31:2], 2'b00};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MEM_IDLE;
      mem_wb_o <= '0;
    end else begin
      state_q  <= state_d;
      mem_wb_o <= wb_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_alu_q        <= '0;
      lat_wdata_q      <= '0;
      lat_rd_q         <= '0;
      lat_we_q         <= 1'b0;
      lat_reg_write_q  <= 1'b0;
      lat_mem_to_reg_q <= 1'b0;
    end else if (latch_en) begin
      lat_alu_q        <= cur_alu;
      lat_wdata_q      <= cur_wdata;
      lat_rd_q         <= cur_rd;
      lat_we_q         <= cur_we;
      lat_reg_write_q  <= cur_rw;
      lat_mem_to_reg_q <= cur_m2r;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_err_o <= 1'b0;
    else        misalign_err_o <= misalign && (state_q == MEM_IDLE);
  end
`endif

endmodule
